// File: rtl/maxpool_engine.sv
// ============================================================================
// maxpool_engine : streams FP16 KxK windows from the data FIFO, writes the
//                  per-window maximum to the output FIFO, one pulse per batch.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_engine #(
   parameter int N_PAR = 16,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          maxpool_ready,
   output logic          maxpool_valid,
   input  logic [15:0]   op_num,
   input  logic [7:0]    kernel_size,
   input  logic [DW-1:0] din,
   input  logic          din_empty,
   output logic          din_rd_en,
   output logic [DW-1:0] dout,
   output logic          dout_we,
   input  logic          dout_full,
   output logic          busy
);

   localparam int CW = (N_PAR > 1) ? $clog2(N_PAR) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EMIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     op_num_q, op_num_d;
   logic [15:0]     win_len_q, win_len_d;
   logic [15:0]     rd_cnt_q, rd_cnt_d;
   logic [15:0]     elem_cnt_q, elem_cnt_d;
   logic [CW-1:0]   ch_cnt_q, ch_cnt_d;
   logic [15:0]     pix_cnt_q, pix_cnt_d;
   logic [DW-1:0]   acc_q, acc_d;
   logic            rd_pend_q, rd_pend_d;

   logic [7:0]      k_eff;
   logic [15:0]     win_len_new;
   logic            last_ch;
   logic            last_pix;
   logic            start;

   // Sign-magnitude compare on raw FP16 bits; ties (including +0 vs -0) keep a.
   function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = a;
      if (a[DW-1] != b[DW-1]) begin
         if ((a[DW-2:0] != '0) || (b[DW-2:0] != '0))
            r = a[DW-1] ? b : a;
      end else if (!a[DW-1]) begin
         if (b[DW-2:0] > a[DW-2:0])
            r = b;
      end else begin
         if (b[DW-2:0] < a[DW-2:0])
            r = b;
      end
      return r;
   endfunction

   assign k_eff       = (kernel_size == 8'd0) ? 8'd1 : kernel_size;
   assign win_len_new = {8'd0, k_eff} * {8'd0, k_eff};
   assign last_ch     = (ch_cnt_q == CW'(N_PAR - 1));
   assign last_pix    = (pix_cnt_q == (op_num_q - 16'd1));
   assign busy        = (state_q != S_IDLE);

   always_comb begin
      state_d       = state_q;
      op_num_d      = op_num_q;
      win_len_d     = win_len_q;
      rd_cnt_d      = rd_cnt_q;
      elem_cnt_d    = elem_cnt_q;
      ch_cnt_d      = ch_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      acc_d         = acc_q;
      din_rd_en     = 1'b0;
      dout_we       = 1'b0;
      dout          = '0;
      maxpool_valid = 1'b0;
      start         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (maxpool_ready)
               start = 1'b1;
         end
         S_FETCH: begin
            din_rd_en = !din_empty && (rd_cnt_q < win_len_q);
            if (din_rd_en)
               rd_cnt_d = rd_cnt_q + 16'd1;
            // rd_pend_q marks that din now holds the element strobed last cycle.
            if (rd_pend_q) begin
               acc_d      = (elem_cnt_q == 16'd0) ? din : fmax(acc_q, din);
               elem_cnt_d = elem_cnt_q + 16'd1;
               if (elem_cnt_q == (win_len_q - 16'd1))
                  state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            dout = acc_q;
            if (!dout_full) begin
               dout_we    = 1'b1;
               rd_cnt_d   = 16'd0;
               elem_cnt_d = 16'd0;
               if (last_ch) begin
                  ch_cnt_d  = '0;
                  pix_cnt_d = pix_cnt_q + 16'd1;
               end else begin
                  ch_cnt_d  = ch_cnt_q + CW'(1);
               end
               state_d = (last_ch && last_pix) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            maxpool_valid = 1'b1;
            if (maxpool_ready)
               start = 1'b1;
            else
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         op_num_d   = op_num;
         win_len_d  = win_len_new;
         rd_cnt_d   = 16'd0;
         elem_cnt_d = 16'd0;
         ch_cnt_d   = '0;
         pix_cnt_d  = 16'd0;
         acc_d      = '0;
         state_d    = (op_num == 16'd0) ? S_DONE : S_FETCH;
      end

      rd_pend_d = din_rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_num_q   <= 16'd0;
         win_len_q  <= 16'd0;
         rd_cnt_q   <= 16'd0;
         elem_cnt_q <= 16'd0;
         ch_cnt_q   <= '0;
         pix_cnt_q  <= 16'd0;
         acc_q      <= '0;
         rd_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_num_q   <= op_num_d;
         win_len_q  <= win_len_d;
         rd_cnt_q   <= rd_cnt_d;
         elem_cnt_q <= elem_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         acc_q      <= acc_d;
         rd_pend_q  <= rd_pend_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_engine.sv
// ============================================================================
// tb_maxpool_engine : directed, table-driven bench for maxpool_engine.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        maxpool_ready = 1'b0;
   logic        maxpool_valid;
   logic [15:0] op_num = 16'd0;
   logic [7:0]  kernel_size = 8'd0;
   logic [15:0] din = 16'd0;
   logic        din_empty = 1'b1;
   logic        din_rd_en;
   logic [15:0] dout;
   logic        dout_we;
   logic        dout_full = 1'b0;
   logic        busy;

   maxpool_engine #(.N_PAR(16), .DW(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .maxpool_ready (maxpool_ready),
      .maxpool_valid (maxpool_valid),
      .op_num        (op_num),
      .kernel_size   (kernel_size),
      .din           (din),
      .din_empty     (din_empty),
      .din_rd_en     (din_rd_en),
      .dout          (dout),
      .dout_we       (dout_we),
      .dout_full     (dout_full),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w [0:8];
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [16];
   logic [15:0] in_q [$];
   logic [15:0] out_q [$];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          rd_total = 0;
   int          we_total = 0;
   int          valid_total = 0;
   bit          stall_en = 1'b0;
   bit          full_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] int2h(input int n);
      int e;
      if (n == 0) return 16'h0000;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      return 16'(((e + 15) << 10) | ((n << (10 - e)) & 'h3FF));
   endfunction

   // FIFO models: data is presented on din the cycle after the strobe.
   initial begin
      logic [15:0] nxt;
      bit          have;
      bit          phase;
      int          cyc;
      have = 1'b0; phase = 1'b0; cyc = 0; nxt = 16'h0;
      forever begin
         @(negedge clk);
         if (din_rd_en) begin
            check("rd_while_empty", {31'd0, din_empty}, 32'd0);
            if (in_q.size() > 0) nxt = in_q.pop_front();
            have = 1'b1;
            rd_total++;
         end
         if (dout_we) begin
            check("wr_while_full", {31'd0, dout_full}, 32'd0);
            out_q.push_back(dout);
            we_total++;
         end
         if (maxpool_valid) valid_total++;
         @(posedge clk);
         #1;
         if (have) din = nxt;
         have  = 1'b0;
         phase = ~phase;
         cyc++;
         din_empty = (in_q.size() == 0) || (stall_en && phase);
         dout_full = full_en && ((cyc % 6) != 5);
      end
   end

   task automatic run(input int op, input int k, input int nb, input int tmo);
      int pulses;
      int cyc;
      pulses = 0;
      cyc = 0;
      @(negedge clk);
      op_num = 16'(op);
      kernel_size = 8'(k);
      maxpool_ready = 1'b1;
      while (pulses < nb && cyc < tmo) begin
         @(negedge clk);
         cyc++;
         if (maxpool_valid) begin
            pulses++;
            if (pulses == nb) maxpool_ready = 1'b0;
         end
      end
      maxpool_ready = 1'b0;
      check("valid_pulses", 32'(pulses), 32'(nb));
   endtask

   task automatic compare(input string name);
      check({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         check(name, {16'd0, out_q[i]}, {16'd0, exp_q[i]});
      out_q.delete();
      exp_q.delete();
   endtask

   // Channel c window: permuted values base+c .. base+c+8, max base+c+8.
   task automatic load_ramp(input int base);
      for (int c = 0; c < 16; c++) begin
         for (int j = 0; j < 9; j++)
            in_q.push_back(int2h(base + c + ((j * 4) % 9)));
         exp_q.push_back(int2h(base + c + 8));
      end
   endtask

   initial begin
      int rd0, we0, lat;

      tbl[0].w = '{16'hC000, 16'hB800, 16'hC700, 16'hBC00, 16'hC200, 16'hB400, 16'hC400, 16'hC880, 16'hBA00};
      tbl[0].exp = 16'hB400;
      tbl[1].w = '{16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000};
      tbl[1].exp = 16'h0000;
      tbl[2].w = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};
      tbl[2].exp = 16'h8000;
      tbl[3].w = '{16'hBC00, 16'h3800, 16'hC000, 16'h3C00, 16'h8000, 16'h3A00, 16'hC400, 16'h0000, 16'hB400};
      tbl[3].exp = 16'h3C00;
      tbl[4].w = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h3800};
      tbl[4].exp = 16'h4800;
      tbl[5].w = '{16'h8000, 16'h0001, 16'h8001, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
      tbl[5].exp = 16'h0001;
      tbl[6].w = '{16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000};
      tbl[6].exp = 16'hC000;
      tbl[7].w = '{16'hC000, 16'hC200, 16'hBC00, 16'hC400, 16'hC000, 16'hB800, 16'hC700, 16'hC880, 16'h0000};
      tbl[7].exp = 16'h0000;
      tbl[8].w = '{16'h3800, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
      tbl[8].exp = 16'h3800;
      tbl[9].w = '{16'h0000, 16'h7800, 16'h7BFF, 16'h0000, 16'h7800, 16'h0000, 16'h3C00, 16'h0000, 16'h0000};
      tbl[9].exp = 16'h7BFF;
      for (int c = 10; c < 16; c++) begin
         for (int j = 0; j < 9; j++) tbl[c].w[j] = int2h(c + (8 - j));
         tbl[c].exp = int2h(c + 8);
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, maxpool_valid}, 32'd0);
      check("rst_rd_en", {31'd0, din_rd_en}, 32'd0);
      check("rst_we", {31'd0, dout_we}, 32'd0);
      check("rst_dout", {16'd0, dout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;

      // Basic ramp windows, K=3, one pixel
      load_ramp(0);
      run(1, 3, 1, 2000);
      compare("t1_dout");

      // Table of mixed-sign and signed-zero windows
      for (int c = 0; c < 16; c++) begin
         for (int j = 0; j < 9; j++) in_q.push_back(tbl[c].w[j]);
         exp_q.push_back(tbl[c].exp);
      end
      run(1, 3, 1, 2000);
      compare("t2_tbl");

      // Flow control: starved input and back-pressured output
      stall_en = 1'b1;
      full_en  = 1'b1;
      load_ramp(0);
      run(1, 3, 1, 5000);
      compare("t3_stall");
      stall_en = 1'b0;
      full_en  = 1'b0;

      // Three back-to-back batches with ready held high
      we0 = we_total;
      for (int b = 0; b < 3; b++)
         for (int p = 0; p < 2; p++)
            for (int c = 0; c < 16; c++) begin
               for (int j = 0; j < 9; j++)
                  in_q.push_back(int2h(b * 20 + p * 3 + c + ((j * 4) % 9)));
               exp_q.push_back(int2h(b * 20 + p * 3 + c + 8));
            end
      run(2, 3, 3, 6000);
      check("t4_writes", 32'(we_total - we0), 32'd96);
      compare("t4_dout");
      @(negedge clk);
      check("t4_busy_idle", {31'd0, busy}, 32'd0);

      // op_num = 0: immediate completion, no FIFO traffic
      rd0 = rd_total;
      we0 = we_total;
      @(negedge clk);
      op_num = 16'd0;
      kernel_size = 8'd3;
      maxpool_ready = 1'b1;
      lat = 0;
      while (lat < 10 && !maxpool_valid) begin
         @(negedge clk);
         lat++;
      end
      maxpool_ready = 1'b0;
      check("t5_op0_latency", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
      repeat (2) @(negedge clk);
      check("t5_op0_reads", 32'(rd_total - rd0), 32'd0);
      check("t5_op0_writes", 32'(we_total - we0), 32'd0);
      check("t5_op0_busy", {31'd0, busy}, 32'd0);

      // K = 0 behaves as pass-through
      rd0 = rd_total;
      for (int c = 0; c < 16; c++) begin
         logic [15:0] v;
         v = int2h(c * 5 + 1) | ((c % 2 == 1) ? 16'h8000 : 16'h0000);
         in_q.push_back(v);
         exp_q.push_back(v);
      end
      run(1, 0, 1, 2000);
      check("t5_k0_reads", 32'(rd_total - rd0), 32'd16);
      compare("t5_k0");

      // Asynchronous reset mid-window, then a clean rerun
      load_ramp(0);
      exp_q.delete();
      @(negedge clk);
      op_num = 16'd1;
      kernel_size = 8'd3;
      maxpool_ready = 1'b1;
      repeat (20) @(negedge clk);
      maxpool_ready = 1'b0;
      check("t6_busy_before", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_rd_en", {31'd0, din_rd_en}, 32'd0);
      check("t6_rst_we", {31'd0, dout_we}, 32'd0);
      check("t6_rst_dout", {16'd0, dout}, 32'd0);
      check("t6_rst_valid", {31'd0, maxpool_valid}, 32'd0);
      in_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      out_q.delete();
      repeat (2) @(negedge clk);
      load_ramp(0);
      run(1, 3, 1, 2000);
      compare("t6_rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
